// File: rtl/tow_pkg.sv
// tow_pkg: shared definitions for the tug-of-war game.
//   - tow_state_e : round sequencer state encoding
//   - LFSR_SEED / LFSR_TAP_MASK / lfsr_next : 16-bit Fibonacci LFSR
//   - WIN_LEFT_CODE / WIN_RIGHT_CODE / score_is_win : scorer win codes,
//     so a top level can derive game_over from the score register.
package tow_pkg;

  typedef enum logic [2:0] {
    ST_RELEASE = 3'd0,
    ST_DELAY   = 3'd1,
    ST_LIGHT   = 3'd2,
    ST_REPORT  = 3'd3,
    ST_HALT    = 3'd4
  } tow_state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Taps 16,14,13,11 counted from the output end of a right-shifting
  // register land on bit indices 0,2,3,5.
  localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;

  localparam logic [6:0] WIN_LEFT_CODE  = 7'b1110000;
  localparam logic [6:0] WIN_RIGHT_CODE = 7'b0000111;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    logic fb;
    fb = ^(cur & LFSR_TAP_MASK);
    return {fb, cur[15:1]};
  endfunction

  function automatic logic score_is_win(input logic [6:0] score);
    return (score == WIN_LEFT_CODE) || (score == WIN_RIGHT_CODE);
  endfunction

endpackage

// File: rtl/tow_round_ctrl_if.sv
// tow_round_ctrl_if: signals between the round sequencer and its
// environment (players' buttons and the scorer).
//   master : environment side, drives pb_l, pb_r, game_over
//   slave  : sequencer side, drives leds_on, winrnd, right, busy, state_dbg
//
// Result contract: there is no valid/ready back-pressure. winrnd is a
// one-cycle valid pulse; right and leds_on are its qualifiers and are
// stable for the whole winrnd cycle. The scorer must take the result in
// that cycle; it cannot stall the sequencer. state_dbg mirrors the FSM
// state register for observation only.
interface tow_round_ctrl_if;
  import tow_pkg::*;

  logic       pb_l;
  logic       pb_r;
  logic       game_over;
  logic       leds_on;
  logic       winrnd;
  logic       right;
  logic       busy;
  tow_state_e state_dbg;

  modport master (
    output pb_l, pb_r, game_over,
    input  leds_on, winrnd, right, busy, state_dbg
  );

  modport slave (
    input  pb_l, pb_r, game_over,
    output leds_on, winrnd, right, busy, state_dbg
  );

endinterface

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded
// with LFSR_SEED on reset and advancing every clock.
//   clk    : clock
//   rst    : asynchronous active-high reset
//   lfsr_o : current register value
module lfsr16
  import tow_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/tow_round_ctrl.sv
// tow_round_ctrl: round sequencer for the tug-of-war game.
// Waits for both buttons released, waits a pseudo-random delay, lights the
// go LEDs, arbitrates the first push and reports it to the scorer with a
// one-cycle winrnd pulse qualified by right/leds_on. Stops in HALT once the
// scorer reports a win; only rst leaves HALT.
//   clk : clock
//   rst : asynchronous active-high reset
//   bus : tow_round_ctrl_if.slave
//         in : pb_l, pb_r (debounced levels), game_over
//         out: leds_on, winrnd, right, busy, state_dbg (all registered)
module tow_round_ctrl
  import tow_pkg::*;
#(
  parameter int MIN_DELAY  = 25_000_000,
  parameter int DELAY_STEP = 1_000_000,
  parameter int RAND_BITS  = 4,
  parameter int TIMEOUT    = 100_000_000,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  tow_round_ctrl_if.slave  bus
);

  logic [15:0] lfsr;

  lfsr16 u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .lfsr_o (lfsr)
  );

  logic lfsr_unused;
  assign lfsr_unused = ^lfsr[15:RAND_BITS];

  // Round delay and timeout loads; a zero load still costs one cycle.
  logic [CNT_W-1:0] delay_raw;
  logic [CNT_W-1:0] delay_load;
  logic [CNT_W-1:0] timeout_load;

  assign delay_raw    = CNT_W'(MIN_DELAY)
                      + CNT_W'(DELAY_STEP) * CNT_W'(lfsr[RAND_BITS-1:0]);
  assign delay_load   = (delay_raw == '0) ? CNT_W'(1) : delay_raw;
  assign timeout_load = (CNT_W'(TIMEOUT) == '0) ? CNT_W'(1) : CNT_W'(TIMEOUT);

  // Push arbitration: a tie goes to the player named by pri_q.
  logic any_push;
  logic tie_push;
  logic push_right;

  tow_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pri_q;
  logic             leds_on_q;
  logic             winrnd_q;
  logic             right_q;
  logic             busy_q;

  assign any_push   = bus.pb_l | bus.pb_r;
  assign tie_push   = bus.pb_l & bus.pb_r;
  assign push_right = tie_push ? pri_q : bus.pb_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RELEASE;
      cnt_q     <= '0;
      pri_q     <= 1'b0;
      leds_on_q <= 1'b0;
      winrnd_q  <= 1'b0;
      right_q   <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      winrnd_q <= 1'b0;
      case (state_q)
        ST_RELEASE: begin
          leds_on_q <= 1'b0;
          if (bus.game_over) begin
            state_q <= ST_HALT;
            busy_q  <= 1'b0;
          end else if (!any_push) begin
            cnt_q   <= delay_load;
            state_q <= ST_DELAY;
          end
        end

        // A push in DELAY is a jump-the-light; leds_on stays as it is
        // (0 in DELAY, 1 in LIGHT) so the scorer sees the right qualifier.
        ST_DELAY, ST_LIGHT: begin
          if (any_push) begin
            right_q  <= push_right;
            winrnd_q <= 1'b1;
            state_q  <= ST_REPORT;
            if (tie_push) begin
              pri_q <= ~pri_q;
            end
          end else if (cnt_q <= CNT_W'(1)) begin
            if (state_q == ST_DELAY) begin
              cnt_q     <= timeout_load;
              leds_on_q <= 1'b1;
              state_q   <= ST_LIGHT;
            end else begin
              leds_on_q <= 1'b0;
              state_q   <= ST_RELEASE;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        ST_REPORT: begin
          leds_on_q <= 1'b0;
          state_q   <= ST_RELEASE;
        end

        ST_HALT: begin
          leds_on_q <= 1'b0;
          busy_q    <= 1'b0;
        end

        default: begin
          leds_on_q <= 1'b0;
          state_q   <= ST_RELEASE;
        end
      endcase
    end
  end

  assign bus.leds_on   = leds_on_q;
  assign bus.winrnd    = winrnd_q;
  assign bus.right     = right_q;
  assign bus.busy      = busy_q;
  assign bus.state_dbg = state_q;

endmodule
